// File: rtl/serial_word_sender.sv
// serial_word_sender: parallel-to-serial feeder for a downstream shift register.
// Takes a word on valid/ready, streams it for WIDTH cycles, pulses DONE, then idles GAP_CYCLES.
module serial_word_sender #(
  parameter int WIDTH      = 10,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             VALID_IN,
  output logic             READY_OUT,
  output logic             SHIFT_EN,
  output logic             SHIFT_DATA,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  // A zero-cycle gap still needs a 1-bit counter; its compare path is never taken.
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : {GAP_W{1'b0}};

  if (WIDTH < 2) begin : g_bad_width
    $error("serial_word_sender: WIDTH must be >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   hold_r;
  logic [CNT_W-1:0]   bit_cnt_r;
  logic [GAP_W-1:0]   gap_cnt_r;
  logic               ready_r;
  logic               shift_en_r;
  logic               shift_data_r;
  logic               busy_r;
  logic               done_r;

  function automatic logic first_bit(input logic [WIDTH-1:0] word);
    return MSB_FIRST ? word[WIDTH-1] : word[0];
  endfunction

  // The hold register is pre-shifted so the next bit always sits in the send-side position.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] word);
    return MSB_FIRST ? {word[WIDTH-2:0], 1'b0} : {1'b0, word[WIDTH-1:1]};
  endfunction

  // Sequencer: handshake, bit streaming, DONE pulse and inter-word gap.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_r      <= ST_IDLE;
      hold_r       <= {WIDTH{1'b0}};
      bit_cnt_r    <= {CNT_W{1'b0}};
      gap_cnt_r    <= {GAP_W{1'b0}};
      ready_r      <= 1'b1;
      shift_en_r   <= 1'b0;
      shift_data_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (VALID_IN && ready_r) begin
            hold_r       <= advance(DATA_IN);
            shift_data_r <= first_bit(DATA_IN);
            shift_en_r   <= 1'b1;
            bit_cnt_r    <= {CNT_W{1'b0}};
            ready_r      <= 1'b0;
            busy_r       <= 1'b1;
            state_r      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bit_cnt_r == BIT_LAST) begin
            shift_en_r   <= 1'b0;
            shift_data_r <= 1'b0;
            done_r       <= 1'b1;
            bit_cnt_r    <= {CNT_W{1'b0}};
            hold_r       <= {WIDTH{1'b0}};
            if (GAP_CYCLES == 0) begin
              ready_r <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              gap_cnt_r <= {GAP_W{1'b0}};
              state_r   <= ST_GAP;
            end
          end else begin
            bit_cnt_r    <= bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            shift_data_r <= first_bit(hold_r);
            hold_r       <= advance(hold_r);
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            gap_cnt_r <= {GAP_W{1'b0}};
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            state_r   <= ST_IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r + {{(GAP_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          hold_r       <= {WIDTH{1'b0}};
          bit_cnt_r    <= {CNT_W{1'b0}};
          gap_cnt_r    <= {GAP_W{1'b0}};
          ready_r      <= 1'b1;
          shift_en_r   <= 1'b0;
          shift_data_r <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  assign READY_OUT  = ready_r;
  assign SHIFT_EN   = shift_en_r;
  assign SHIFT_DATA = shift_data_r;
  assign BUSY       = busy_r;
  assign DONE       = done_r;

endmodule

// File: tb/tb_serial_word_sender.sv
// Scoreboard bench for serial_word_sender: MSB-first/gap 2, LSB-first/gap 2 and MSB-first/gap 0
// instances, each feeding a 10-bit behavioural shift register.
module tb_serial_word_sender;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] data_ab = '0;
  logic [W-1:0] data_c = '0;
  logic         valid_ab = 1'b0;
  logic         valid_c = 1'b0;

  logic ready_a, en_a, sd_a, busy_a, done_a;
  logic ready_b, en_b, sd_b, busy_b, done_b;
  logic ready_c, en_c, sd_c, busy_c, done_c;

  logic [W-1:0] sr_a = '0;
  logic [W-1:0] sr_b = '0;
  logic [W-1:0] sr_c = '0;

  logic q_a[$];
  logic q_b[$];
  logic q_c[$];

  int chk_cnt = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  serial_word_sender #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) dut_a (
    .CLK(clk), .RSTn(rst_n), .DATA_IN(data_ab), .VALID_IN(valid_ab), .READY_OUT(ready_a),
    .SHIFT_EN(en_a), .SHIFT_DATA(sd_a), .BUSY(busy_a), .DONE(done_a)
  );

  serial_word_sender #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP_CYCLES(2)) dut_b (
    .CLK(clk), .RSTn(rst_n), .DATA_IN(data_ab), .VALID_IN(valid_ab), .READY_OUT(ready_b),
    .SHIFT_EN(en_b), .SHIFT_DATA(sd_b), .BUSY(busy_b), .DONE(done_b)
  );

  serial_word_sender #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) dut_c (
    .CLK(clk), .RSTn(rst_n), .DATA_IN(data_c), .VALID_IN(valid_c), .READY_OUT(ready_c),
    .SHIFT_EN(en_c), .SHIFT_DATA(sd_c), .BUSY(busy_c), .DONE(done_c)
  );

  // Downstream shift registers: shift in at every enabled rising edge.
  always @(posedge clk) begin
    if (en_a) sr_a <= {sr_a[W-2:0], sd_a};
    if (en_b) sr_b <= {sr_b[W-2:0], sd_b};
    if (en_c) sr_c <= {sr_c[W-2:0], sd_c};
  end

  // Output vectors below are {READY_OUT, SHIFT_EN, SHIFT_DATA, BUSY, DONE}.
  task automatic test_reset();
    rst_n = 1'b0;
    valid_ab = 1'b0;
    valid_c = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({ready_a, en_a, sd_a, busy_a, done_a} !== 5'b10000)
      $display("FAIL reset_a got=%b exp=%b", {ready_a, en_a, sd_a, busy_a, done_a}, 5'b10000);
    else pass_cnt++;
    chk_cnt++;
    if ({ready_b, en_b, sd_b, busy_b, done_b} !== 5'b10000)
      $display("FAIL reset_b got=%b exp=%b", {ready_b, en_b, sd_b, busy_b, done_b}, 5'b10000);
    else pass_cnt++;
    chk_cnt++;
    if ({ready_c, en_c, sd_c, busy_c, done_c} !== 5'b10000)
      $display("FAIL reset_c got=%b exp=%b", {ready_c, en_c, sd_c, busy_c, done_c}, 5'b10000);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if ({ready_a, en_a, sd_a, busy_a, done_a} !== 5'b10000)
      $display("FAIL post_reset_a got=%b exp=%b", {ready_a, en_a, sd_a, busy_a, done_a}, 5'b10000);
    else pass_cnt++;
    chk_cnt++;
    if ({ready_c, en_c, sd_c, busy_c, done_c} !== 5'b10000)
      $display("FAIL post_reset_c got=%b exp=%b", {ready_c, en_c, sd_c, busy_c, done_c}, 5'b10000);
    else pass_cnt++;
  endtask

  // Same word into the MSB-first and LSB-first instances; negedge n shows what edge t0+n samples.
  task automatic test_bit_order();
    logic [W-1:0] w;
    logic [W-1:0] rev;
    logic         exp_a, exp_b;
    logic [4:0]   ea, eb;
    w = 10'b1011001110;
    for (int i = 0; i < W; i++) begin
      q_a.push_back(w[W-1-i]);
      q_b.push_back(w[i]);
      rev[W-1-i] = w[i];
    end
    data_ab = w;
    valid_ab = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      @(negedge clk);
      valid_ab = 1'b0;
      data_ab = '0;
      exp_a = 1'b0;
      exp_b = 1'b0;
      if (n <= W && q_a.size() > 0) exp_a = q_a.pop_front();
      if (n <= W && q_b.size() > 0) exp_b = q_b.pop_front();
      ea = {(n >= 13), (n <= W), exp_a, (n <= 12), (n == 11)};
      eb = {(n >= 13), (n <= W), exp_b, (n <= 12), (n == 11)};
      chk_cnt++;
      if ({ready_a, en_a, sd_a, busy_a, done_a} !== ea)
        $display("FAIL msb_first n=%0d got=%b exp=%b", n, {ready_a, en_a, sd_a, busy_a, done_a}, ea);
      else pass_cnt++;
      chk_cnt++;
      if ({ready_b, en_b, sd_b, busy_b, done_b} !== eb)
        $display("FAIL lsb_first n=%0d got=%b exp=%b", n, {ready_b, en_b, sd_b, busy_b, done_b}, eb);
      else pass_cnt++;
    end
    chk_cnt++;
    if (sr_a !== w) $display("FAIL msb_contents got=%b exp=%b", sr_a, w);
    else pass_cnt++;
    chk_cnt++;
    if (sr_b !== rev) $display("FAIL lsb_contents got=%b exp=%b", sr_b, rev);
    else pass_cnt++;
  endtask

  // GAP_CYCLES=0 with VALID_IN held: second word starts right after the DONE cycle.
  task automatic test_back_to_back();
    logic       exp_sd;
    logic       en_exp, end_cyc;
    logic [4:0] ec;
    for (int i = 0; i < W; i++) q_c.push_back(1'b1);
    for (int i = 0; i < W; i++) q_c.push_back(1'b0);
    data_c = 10'h3FF;
    valid_c = 1'b1;
    for (int n = 1; n <= 22; n++) begin
      @(negedge clk);
      if (n == 1) data_c = 10'h000;
      if (n == 12) valid_c = 1'b0;
      end_cyc = (n == 11) || (n == 22);
      en_exp = !end_cyc;
      exp_sd = 1'b0;
      if (en_exp && q_c.size() > 0) exp_sd = q_c.pop_front();
      ec = {end_cyc, en_exp, exp_sd, !end_cyc, end_cyc};
      chk_cnt++;
      if ({ready_c, en_c, sd_c, busy_c, done_c} !== ec)
        $display("FAIL back_to_back n=%0d got=%b exp=%b", n, {ready_c, en_c, sd_c, busy_c, done_c}, ec);
      else pass_cnt++;
    end
    chk_cnt++;
    if (sr_c !== 10'h000) $display("FAIL b2b_contents got=%h exp=%h", sr_c, 10'h000);
    else pass_cnt++;
  endtask

  // VALID_IN pulse and DATA_IN change mid-word must be ignored.
  task automatic test_ignore_mid_word();
    logic [W-1:0] w;
    logic         exp_a;
    logic [4:0]   ea;
    int           dones;
    w = 10'h2C9;
    dones = 0;
    for (int i = 0; i < W; i++) q_a.push_back(w[W-1-i]);
    data_ab = w;
    valid_ab = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (n == 1) valid_ab = 1'b0;
      if (n == 4) begin
        valid_ab = 1'b1;
        data_ab = 10'h155;
      end
      if (n == 5) begin
        valid_ab = 1'b0;
        data_ab = '0;
      end
      exp_a = 1'b0;
      if (n <= W && q_a.size() > 0) exp_a = q_a.pop_front();
      ea = {(n >= 13), (n <= W), exp_a, (n <= 12), (n == 11)};
      if (done_a === 1'b1) dones++;
      chk_cnt++;
      if ({ready_a, en_a, sd_a, busy_a, done_a} !== ea)
        $display("FAIL ignore_mid n=%0d got=%b exp=%b", n, {ready_a, en_a, sd_a, busy_a, done_a}, ea);
      else pass_cnt++;
    end
    chk_cnt++;
    if (dones != 1) $display("FAIL ignore_done_count got=%0d exp=%0d", dones, 1);
    else pass_cnt++;
    chk_cnt++;
    if (sr_a !== w) $display("FAIL ignore_contents got=%h exp=%h", sr_a, w);
    else pass_cnt++;
  endtask

  // Reset after four bits: outputs fall at once, no DONE, next word starts from bit 0.
  task automatic test_reset_mid_word();
    logic [W-1:0] w;
    logic         exp_a;
    logic [4:0]   ea;
    w = 10'h3A6;
    for (int i = 0; i < W; i++) q_a.push_back(w[W-1-i]);
    data_ab = w;
    valid_ab = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      valid_ab = 1'b0;
      exp_a = 1'b0;
      if (q_a.size() > 0) exp_a = q_a.pop_front();
      ea = {1'b0, 1'b1, exp_a, 1'b1, 1'b0};
      chk_cnt++;
      if ({ready_a, en_a, sd_a, busy_a, done_a} !== ea)
        $display("FAIL pre_abort n=%0d got=%b exp=%b", n, {ready_a, en_a, sd_a, busy_a, done_a}, ea);
      else pass_cnt++;
    end
    rst_n = 1'b0;
    #1;
    q_a.delete();
    chk_cnt++;
    if ({ready_a, en_a, sd_a, busy_a, done_a} !== 5'b10000)
      $display("FAIL async_abort got=%b exp=%b", {ready_a, en_a, sd_a, busy_a, done_a}, 5'b10000);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      chk_cnt++;
      if ({ready_a, en_a, sd_a, busy_a, done_a} !== 5'b10000)
        $display("FAIL abort_idle n=%0d got=%b exp=%b", n, {ready_a, en_a, sd_a, busy_a, done_a}, 5'b10000);
      else pass_cnt++;
    end
    w = 10'h0F3;
    for (int i = 0; i < W; i++) q_a.push_back(w[W-1-i]);
    data_ab = w;
    valid_ab = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      @(negedge clk);
      valid_ab = 1'b0;
      exp_a = 1'b0;
      if (n <= W && q_a.size() > 0) exp_a = q_a.pop_front();
      ea = {(n >= 13), (n <= W), exp_a, (n <= 12), (n == 11)};
      chk_cnt++;
      if ({ready_a, en_a, sd_a, busy_a, done_a} !== ea)
        $display("FAIL after_abort n=%0d got=%b exp=%b", n, {ready_a, en_a, sd_a, busy_a, done_a}, ea);
      else pass_cnt++;
    end
    chk_cnt++;
    if (sr_a !== w) $display("FAIL after_abort_contents got=%h exp=%h", sr_a, w);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_bit_order();
    test_back_to_back();
    test_ignore_mid_word();
    test_reset_mid_word();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
